mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous 4 KB memory (10-bit word address) between the instruction-fetch requester and the data (load/store) requester.
- Allows the multicycle core to run from a unified memory.
- Sits between the core's fetch/memory-access stages and the memory macro.
- Per-requester req/gnt handshake, one transaction in flight, configurable memory read latency, starvation-bounded priority arbitration.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_arb_pick.sv | 33 +++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
//   state_e : arbiter FSM state (IDLE = may grant, WAIT = counting read latency)
//   owner_e : which requester owns the transaction in flight
package mem_port_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Deepest memory read latency the latency counter can track.
  localparam int MEM_LAT_MAX = 7;
  localparam int CNT_W       = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
//   i_*    : instruction-fetch requester (req/gnt, response)
//   d_*    : data load/store requester (req/gnt, response)
//   m_*    : single-port synchronous memory macro
//   busy   : a transaction is in flight
// Modports: slave = the arbiter; master = requesters plus memory.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic [9:0]  m_addr;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  logic        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_addr, m_we, m_be, m_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_addr, m_we, m_be, m_wdata, busy
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
//   i_req, d_req : raw requests
//   starved      : fetch port has been denied STARVE_MAX cycles (RR_MODE = 0)
//   prefer_d     : round-robin pointer says data goes next (RR_MODE = 1)
//   win_i, win_d : one-hot (or zero) winner; caller gates with arbitration-open
module mem_arb_pick #(
  parameter bit RR_MODE = 1'b0
) (
  input  logic i_req,
  input  logic d_req,
  input  logic starved,
  input  logic prefer_d,
  output logic win_i,
  output logic win_d
);

  logic d_first;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    win_i   = 1'b0;
    win_d   = 1'b0;
    d_first = RR_MODE ? prefer_d : !starved;
    if (i_req && d_req) begin
      win_d = d_first;
      win_i = !d_first;
    end else begin
      win_i = i_req;
      win_d = d_req;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the instruction-fetch and
// data requesters. One transaction in flight; response MEM_LAT cycles after
// the grant; back-to-back issue allowed in the response cycle.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : requester/memory signal bundle (slave side)
// Parameters: MEM_LAT (1..7), STARVE_MAX, RR_MODE (0 = data priority with
// starvation guard, 1 = strict round-robin).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4,
  parameter bit RR_MODE    = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  mem_port_arbiter_if.slave bus
);

  if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_lat_chk
    $error("mem_port_arbiter: MEM_LAT out of range 1..7");
  end

  localparam int               SW       = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] LAT_C    = CNT_W'(MEM_LAT);
  localparam logic [SW-1:0]    STARVE_C = SW'(STARVE_MAX);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  owner_e           rr_ptr_q, rr_ptr_d;   // port preferred on the next contested grant
  logic [CNT_W-1:0] cnt_q, cnt_d;         // cycles since grant
  logic [SW-1:0]    starve_q, starve_d;
  logic             store_q, store_d;     // in-flight transaction is a store

  logic resp, arb_open, pick_i, pick_d, gnt_i, gnt_d;
  logic i_rvalid, d_rvalid;

  assign resp = (state_q == WAIT) && (cnt_q == LAT_C);
  // Grants are combinational from req, so reset must mask them explicitly.
  assign arb_open = !rst && ((state_q == IDLE) || resp);

  mem_arb_pick #(.RR_MODE(RR_MODE)) u_pick (
    .i_req    (bus.i_req),
    .d_req    (bus.d_req),
    .starved  (starve_q >= STARVE_C),
    .prefer_d (rr_ptr_q == OWN_D),
    .win_i    (pick_i),
    .win_d    (pick_d)
  );

  assign gnt_i = arb_open && pick_i;
  assign gnt_d = arb_open && pick_d;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    store_d  = store_q;
    starve_d = starve_q;

    if ((state_q == WAIT) && !resp) cnt_d = cnt_q + 1'b1;

    if (resp) begin
      state_d = IDLE;
      owner_d = OWN_NONE;
      cnt_d   = '0;
      store_d = 1'b0;
    end

    // A grant in the response cycle overrides the return to IDLE.
    if (gnt_i || gnt_d) begin
      state_d  = WAIT;
      owner_d  = gnt_i ? OWN_I : OWN_D;
      rr_ptr_d = gnt_i ? OWN_D : OWN_I;
      cnt_d    = CNT_W'(1);
      store_d  = gnt_d && bus.d_we;
    end

    // Counts denied fetch cycles, including cycles spent waiting on memory.
    if (!bus.i_req || gnt_i)       starve_d = '0;
    else if (starve_q < STARVE_C)  starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      rr_ptr_q <= OWN_I;
      cnt_q    <= '0;
      starve_q <= '0;
      store_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      store_q  <= store_d;
    end
  end

  assign i_rvalid = resp && (owner_q == OWN_I);
  assign d_rvalid = resp && (owner_q == OWN_D);

  assign bus.i_gnt    = gnt_i;
  assign bus.d_gnt    = gnt_d;
  assign bus.i_rvalid = i_rvalid;
  assign bus.d_rvalid = d_rvalid;
  assign bus.i_rdata  = i_rvalid ? bus.m_rdata : '0;
  assign bus.d_rdata  = (d_rvalid && !store_q) ? bus.m_rdata : '0;

  // Memory side is driven only during the grant cycle.
  assign bus.m_addr  = gnt_i ? bus.i_addr[11:2] : (gnt_d ? bus.d_addr[11:2] : '0);
  assign bus.m_we    = gnt_d && bus.d_we;
  assign bus.m_be    = gnt_i ? 4'hF : (gnt_d ? bus.d_be : 4'h0);
  assign bus.m_wdata = gnt_d ? bus.d_wdata : '0;

  assign bus.busy = (state_q == WAIT) && !(resp && (gnt_i || gnt_d));

  // Byte-offset and above-4KB address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_addr[31:12], bus.i_addr[1:0],
                              bus.d_addr[31:12], bus.d_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Four instances with different
// parameters share one clock:
//   0: MEM_LAT=1 RR_MODE=0   1: MEM_LAT=3 RR_MODE=0
//   2: MEM_LAT=1 RR_MODE=1   3: MEM_LAT=4 RR_MODE=0
module tb_mem_port_arbiter;

  localparam int N = 4;

  function automatic int lat_of(input int g);
    case (g)
      1:       return 3;
      3:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic bit rr_of(input int g);
    return (g == 2);
  endfunction

  // Power-on contents of every memory word.
  function automatic logic [31:0] init_pat(input int a);
    return 32'hA5A5_0000 | 32'(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst_v, i_req_v, d_req_v, d_we_v;
  logic [N-1:0] i_gnt_v, i_rvalid_v, d_gnt_v, d_rvalid_v, m_we_v, busy_v;
  logic [31:0]  i_addr_v [N];
  logic [31:0]  d_addr_v [N];
  logic [31:0]  d_wdata_v [N];
  logic [3:0]   d_be_v [N];
  logic [31:0]  i_rdata_v [N];
  logic [31:0]  d_rdata_v [N];
  logic [9:0]   m_addr_v [N];
  logic [3:0]   m_be_v [N];
  logic [31:0]  m_wdata_v [N];

  // Pipelined write-first memory model: read data of the address presented at
  // cycle T appears on m_rdata at T+MEM_LAT.
  logic [31:0] mem  [N][1024];
  logic [31:0] pipe [N][8];
  bit          mem_ready;

  always @(posedge clk) begin
    if (!mem_ready) begin
      // NOTE: the model memory is filled once on the first edge, not by reset;
      // the arbiter itself holds no storage array.
      for (int k = 0; k < N; k++)
        for (int a = 0; a < 1024; a++) mem[k][a] <= init_pat(a);
      mem_ready <= 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_we_v[k]) begin
          mem[k][m_addr_v[k]] <= merge(mem[k][m_addr_v[k]], m_wdata_v[k], m_be_v[k]);
          pipe[k][0]          <= merge(mem[k][m_addr_v[k]], m_wdata_v[k], m_be_v[k]);
        end else begin
          pipe[k][0] <= mem[k][m_addr_v[k]];
        end
        for (int s = 1; s < 8; s++) pipe[k][s] <= pipe[k][s-1];
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_port_arbiter_if bus ();

    assign bus.i_req   = i_req_v[g];
    assign bus.i_addr  = i_addr_v[g];
    assign bus.d_req   = d_req_v[g];
    assign bus.d_we    = d_we_v[g];
    assign bus.d_be    = d_be_v[g];
    assign bus.d_addr  = d_addr_v[g];
    assign bus.d_wdata = d_wdata_v[g];
    assign bus.m_rdata = pipe[g][lat_of(g)-1];

    assign i_gnt_v[g]    = bus.i_gnt;
    assign i_rvalid_v[g] = bus.i_rvalid;
    assign i_rdata_v[g]  = bus.i_rdata;
    assign d_gnt_v[g]    = bus.d_gnt;
    assign d_rvalid_v[g] = bus.d_rvalid;
    assign d_rdata_v[g]  = bus.d_rdata;
    assign m_addr_v[g]   = bus.m_addr;
    assign m_we_v[g]     = bus.m_we;
    assign m_be_v[g]     = bus.m_be;
    assign m_wdata_v[g]  = bus.m_wdata;
    assign busy_v[g]     = bus.busy;

    mem_port_arbiter #(
      .MEM_LAT    (lat_of(g)),
      .STARVE_MAX (4),
      .RR_MODE    (rr_of(g))
    ) u_dut (
      .clk (clk),
      .rst (rst_v[g]),
      .bus (bus)
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Packed view: {i_gnt, d_gnt, i_rvalid, d_rvalid, busy, m_we, m_be, m_addr}
  function automatic logic [19:0] obs(input int k);
    return {i_gnt_v[k], d_gnt_v[k], i_rvalid_v[k], d_rvalid_v[k], busy_v[k],
            m_we_v[k], m_be_v[k], m_addr_v[k]};
  endfunction

  function automatic logic [19:0] mk(input logic ig, input logic dg, input logic irv,
                                     input logic drv, input logic bsy, input logic we,
                                     input logic [3:0] be, input logic [9:0] a);
    return {ig, dg, irv, drv, bsy, we, be, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input int k, input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
    d_req_v[k]   = req;
    d_we_v[k]    = we;
    d_be_v[k]    = be;
    d_addr_v[k]  = addr;
    d_wdata_v[k] = wd;
  endtask

  // Single data transaction from IDLE with no follow-up request.
  task automatic run_d(input int k, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [9:0] word,
                       input int lat, input logic [31:0] exp_rdata, input string name);
    set_d(k, 1'b1, we, be, addr, wd);
    @(negedge clk);
    check({name, "_gnt"}, obs(k), mk(0, 1, 0, 0, 0, we, be, word));
    check({name, "_wdata"}, m_wdata_v[k], wd);
    tick();
    d_req_v[k] = 1'b0;
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      check({name, "_wait"}, obs(k), mk(0, 0, 0, 0, 1, 0, 4'h0, 10'd0));
      tick();
    end
    @(negedge clk);
    check({name, "_rv"}, obs(k), mk(0, 0, 0, 1, 1, 0, 4'h0, 10'd0));
    check({name, "_rdata"}, d_rdata_v[k], exp_rdata);
    tick();
    @(negedge clk);
    check({name, "_idle"}, obs(k), 20'h0);
    tick();
  endtask

  typedef struct packed {
    logic i_req, d_req;
    logic eg, dg, irv, drv, bsy;
  } vec_t;

  vec_t vecs [17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Starvation-guard sequence on instance 0 (MEM_LAT=1, data priority).
    // i_addr=0x10 -> word 4, d_addr=0x40 -> word 16.
    vecs[0]  = '{1, 0, 1, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 1, 0, 1};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 1, 0, 1, 0, 0, 0};
    vecs[4]  = '{1, 1, 0, 1, 0, 1, 0};
    vecs[5]  = '{1, 1, 0, 1, 0, 1, 0};
    vecs[6]  = '{1, 1, 0, 1, 0, 1, 0};
    vecs[7]  = '{1, 1, 1, 0, 0, 1, 0};
    vecs[8]  = '{1, 1, 0, 1, 1, 0, 0};
    vecs[9]  = '{0, 1, 0, 1, 0, 1, 0};
    vecs[10] = '{1, 1, 0, 1, 0, 1, 0};
    vecs[11] = '{1, 1, 0, 1, 0, 1, 0};
    vecs[12] = '{1, 1, 0, 1, 0, 1, 0};
    vecs[13] = '{1, 1, 0, 1, 0, 1, 0};
    vecs[14] = '{1, 1, 1, 0, 0, 1, 0};
    vecs[15] = '{0, 0, 0, 0, 1, 0, 1};
    vecs[16] = '{0, 0, 0, 0, 0, 0, 0};

    rst_v   = '1;
    i_req_v = '0;
    for (int k = 0; k < N; k++) begin
      i_addr_v[k] = 32'h0000_0010;
      set_d(k, 1'b0, 1'b0, 4'hF, 32'h0000_0040, 32'h0);
    end
    i_req_v[0] = 1'b1;   // request held during reset must not be granted

    tick();
    tick();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check($sformatf("reset_obs_%0d", k), obs(k), 20'h0);
      check($sformatf("reset_rdata_%0d", k), {i_rdata_v[k], d_rdata_v[k]}, 64'h0);
      check($sformatf("reset_wdata_%0d", k), m_wdata_v[k], 32'h0);
    end
    tick();
    i_req_v[0] = 1'b0;
    rst_v      = '0;

    // Table-driven arbitration on instance 0.
    for (int n = 0; n < 17; n++) begin
      i_req_v[0] = vecs[n].i_req;
      d_req_v[0] = vecs[n].d_req;
      @(negedge clk);
      check($sformatf("tab_obs_%0d", n), obs(0),
            mk(vecs[n].eg, vecs[n].dg, vecs[n].irv, vecs[n].drv, vecs[n].bsy, 1'b0,
               (vecs[n].eg || vecs[n].dg) ? 4'hF : 4'h0,
               vecs[n].eg ? 10'd4 : (vecs[n].dg ? 10'd16 : 10'd0)));
      check($sformatf("tab_irdata_%0d", n), i_rdata_v[0], vecs[n].irv ? 32'hA5A5_0004 : 32'h0);
      check($sformatf("tab_drdata_%0d", n), d_rdata_v[0], vecs[n].drv ? 32'hA5A5_0010 : 32'h0);
      tick();
    end

    // Instance 1 (MEM_LAT=3): load with ignored address bits, then clear word 8.
    run_d(1, 1'b0, 4'hF, 32'hABCD_5027, 32'h1234_5678, 10'd9, 3, 32'hA5A5_0009, "b_load9");
    run_d(1, 1'b1, 4'hF, 32'h0000_0020, 32'h0000_0000, 10'd8, 3, 32'h0, "b_clear8");

    // Partial store then load held through the busy window (back-to-back issue).
    set_d(1, 1'b1, 1'b1, 4'b0011, 32'h0000_0020, 32'hDEAD_BEEF);
    @(negedge clk);
    check("st_gnt", obs(1), mk(0, 1, 0, 0, 0, 1, 4'b0011, 10'd8));
    check("st_wdata", m_wdata_v[1], 32'hDEAD_BEEF);
    tick();
    set_d(1, 1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("st_wait_%0d", c), obs(1), mk(0, 0, 0, 0, 1, 0, 4'h0, 10'd0));
      tick();
    end
    @(negedge clk);
    check("st_rv_ld_gnt", obs(1), mk(0, 1, 0, 1, 0, 0, 4'hF, 10'd8));
    check("st_rdata_zero", d_rdata_v[1], 32'h0);
    tick();
    d_req_v[1] = 1'b0;
    for (int c = 4; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("ld_wait_%0d", c), obs(1), mk(0, 0, 0, 0, 1, 0, 4'h0, 10'd0));
      tick();
    end
    @(negedge clk);
    check("ld_rv", obs(1), mk(0, 0, 0, 1, 1, 0, 4'h0, 10'd0));
    check("ld_rdata", d_rdata_v[1], 32'h0000_BEEF);
    tick();
    @(negedge clk);
    check("ld_idle", obs(1), 20'h0);
    tick();

    // Instance 2 (RR_MODE=1): both held -> I,D,I,D,... then single requester wins.
    i_req_v[2] = 1'b1;
    d_req_v[2] = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (n % 2 == 0)
        check($sformatf("rr_i_%0d", n), obs(2), mk(1, 0, 0, n > 0, 0, 0, 4'hF, 10'd4));
      else
        check($sformatf("rr_d_%0d", n), obs(2), mk(0, 1, 1, 0, 0, 0, 4'hF, 10'd16));
      tick();
    end
    i_req_v[2] = 1'b0;
    @(negedge clk);
    check("rr_single_d", obs(2), mk(0, 1, 0, 1, 0, 0, 4'hF, 10'd16));
    tick();
    d_req_v[2] = 1'b0;
    @(negedge clk);
    check("rr_last_rv", obs(2), mk(0, 0, 0, 1, 1, 0, 4'h0, 10'd0));
    tick();

    // Instance 3 (MEM_LAT=4): reset two cycles after a grant discards the response.
    i_req_v[3] = 1'b1;
    @(negedge clk);
    check("rst_mid_gnt", obs(3), mk(1, 0, 0, 0, 0, 0, 4'hF, 10'd4));
    tick();
    i_req_v[3] = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", obs(3), mk(0, 0, 0, 0, 1, 0, 4'h0, 10'd0));
    tick();
    rst_v[3] = 1'b1;
    #1;
    check("rst_mid_now", obs(3), 20'h0);
    tick();
    rst_v[3] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("rst_after_%0d", c), obs(3), 20'h0);
      check($sformatf("rst_after_rdata_%0d", c), i_rdata_v[3], 32'h0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
